// File: rtl/sr_register_bank.sv
// -----------------------------------------------------------------------------
// sr_register_bank
//   Bank of CH clocked SR storage channels behind one shared update gate.
//   The s=r=1 case is resolved at run time by 'mode': strict (hold + flag),
//   set-dominant, reset-dominant or toggle. Each channel also produces
//   registered rise/fall pulses and a sticky illegal-input flag. A saturating
//   counter tallies cycles that contained at least one illegal event.
//
//   Optional feature (compile-time macro SR_GLITCH_FILTER_EN):
//     Each channel's raw {s,r} pair must stay stable for FILTER_CYCLES
//     consecutive samples before it is committed to a filtered pair {sf,rf},
//     which then drives the SR logic. Without the macro, raw s/r feed the
//     SR logic directly and no filter registers exist.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (highest priority)
//   control    1 = channels may update, 0 = q/illegal/err_count hold
//   s, r       per-channel set / reset requests
//   mode       s=r=1 resolution: 00 strict, 01 set, 10 reset, 11 toggle
//   clr_err    clears illegal[] and err_count
//   q          stored channel values
//   q_rise     one-cycle pulse in the first cycle q[i] reads 1
//   q_fall     one-cycle pulse in the first cycle q[i] reads 0
//   illegal    sticky flag: channel saw s=r=1 in strict mode
//   err_count  saturating count of cycles with any illegal event
// -----------------------------------------------------------------------------
module sr_register_bank #(
   parameter int              CH            = 8,
   parameter int              CNT_W         = 8,
   parameter logic [CH-1:0]   RESET_VAL     = {CH{1'b0}},
   parameter int              FILTER_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              control,
   input  logic [CH-1:0]     s,
   input  logic [CH-1:0]     r,
   input  logic [1:0]        mode,
   input  logic              clr_err,
   output logic [CH-1:0]     q,
   output logic [CH-1:0]     q_rise,
   output logic [CH-1:0]     q_fall,
   output logic [CH-1:0]     illegal,
   output logic [CNT_W-1:0]  err_count
);

   localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

   localparam logic [1:0] MODE_STRICT = 2'b00;
   localparam logic [1:0] MODE_SET    = 2'b01;
   localparam logic [1:0] MODE_RESET  = 2'b10;
   localparam logic [1:0] MODE_TOGGLE = 2'b11;

   // Elaboration-time parameter range guards
   if ((CH < 1) || (CH > 64)) begin : g_bad_ch
      $error("sr_register_bank: CH must be in 1..64");
   end
   if ((FILTER_CYCLES < 1) || (FILTER_CYCLES > 15)) begin : g_bad_filter
      $error("sr_register_bank: FILTER_CYCLES must be in 1..15");
   end

   // Saturating increment for the illegal-event counter
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] res;
      if (v == ERR_MAX) begin
         res = ERR_MAX;
      end else begin
         res = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

   // Effective set/reset pair seen by the SR logic
   logic [CH-1:0] s_eff;
   logic [CH-1:0] r_eff;

`ifdef SR_GLITCH_FILTER_EN
   localparam logic [3:0] FILT_THR = 4'(FILTER_CYCLES);

   logic [CH-1:0] s_prev_q, s_prev_d;
   logic [CH-1:0] r_prev_q, r_prev_d;
   logic [CH-1:0] sf_q, sf_d;
   logic [CH-1:0] rf_q, rf_d;
   logic [3:0]    stab_q [CH];
   logic [3:0]    stab_d [CH];

   // Stability counters: restart on any raw change, commit once the window is met.
   // They run independently of 'control'; only the q update is gated.
   always_comb begin
      s_prev_d = s;
      r_prev_d = r;
      sf_d     = sf_q;
      rf_d     = rf_q;
      for (int i = 0; i < CH; i++) begin
         if ((s[i] != s_prev_q[i]) || (r[i] != r_prev_q[i])) begin
            // This sample is the first of a new stable run
            stab_d[i] = 4'd1;
         end else if (stab_q[i] == 4'hF) begin
            stab_d[i] = 4'hF;
         end else begin
            stab_d[i] = stab_q[i] + 4'd1;
         end
         if (stab_d[i] >= FILT_THR) begin
            sf_d[i] = s[i];
            rf_d[i] = r[i];
         end else begin
            sf_d[i] = sf_q[i];
            rf_d[i] = rf_q[i];
         end
      end
   end

   // Filter state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         s_prev_q <= {CH{1'b0}};
         r_prev_q <= {CH{1'b0}};
         sf_q     <= {CH{1'b0}};
         rf_q     <= {CH{1'b0}};
         for (int i = 0; i < CH; i++) begin
            stab_q[i] <= 4'd0;
         end
      end else begin
         s_prev_q <= s_prev_d;
         r_prev_q <= r_prev_d;
         sf_q     <= sf_d;
         rf_q     <= rf_d;
         for (int i = 0; i < CH; i++) begin
            stab_q[i] <= stab_d[i];
         end
      end
   end

   assign s_eff = sf_q;
   assign r_eff = rf_q;
`else
   assign s_eff = s;
   assign r_eff = r;
`endif

   logic [CH-1:0]    q_q, q_d;
   logic [CH-1:0]    rise_q, rise_d;
   logic [CH-1:0]    fall_q, fall_d;
   logic [CH-1:0]    ill_q, ill_d;
   logic [CH-1:0]    ill_ev_s;
   logic [CNT_W-1:0] err_q, err_d;
   logic             any_ill_s;

   // Per-channel SR next-state with mode-dependent s=r=1 resolution
   always_comb begin
      q_d      = q_q;
      ill_ev_s = {CH{1'b0}};
      if (control) begin
         for (int i = 0; i < CH; i++) begin
            case ({s_eff[i], r_eff[i]})
               2'b00: q_d[i] = q_q[i];
               2'b01: q_d[i] = 1'b0;
               2'b10: q_d[i] = 1'b1;
               2'b11: begin
                  case (mode)
                     MODE_STRICT: begin
                        q_d[i]      = q_q[i];
                        ill_ev_s[i] = 1'b1;
                     end
                     MODE_SET:    q_d[i] = 1'b1;
                     MODE_RESET:  q_d[i] = 1'b0;
                     MODE_TOGGLE: q_d[i] = ~q_q[i];
                     default:     q_d[i] = q_q[i];
                  endcase
               end
               default: q_d[i] = q_q[i];
            endcase
         end
      end else begin
         q_d      = q_q;
         ill_ev_s = {CH{1'b0}};
      end
   end

   assign any_ill_s = |ill_ev_s;

   // Edge pulses, sticky flags and saturating error count
   always_comb begin
      rise_d = q_d & ~q_q;
      fall_d = ~q_d & q_q;
      if (clr_err) begin
         // A fresh event in the clearing cycle survives the clear
         ill_d = ill_ev_s;
         if (any_ill_s) begin
            err_d = {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            err_d = {CNT_W{1'b0}};
         end
      end else begin
         ill_d = ill_q | ill_ev_s;
         if (any_ill_s) begin
            err_d = sat_inc(err_q);
         end else begin
            err_d = err_q;
         end
      end
   end

   // Output state registers; reset wins over every other input
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q    <= RESET_VAL;
         rise_q <= {CH{1'b0}};
         fall_q <= {CH{1'b0}};
         ill_q  <= {CH{1'b0}};
         err_q  <= {CNT_W{1'b0}};
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         ill_q  <= ill_d;
         err_q  <= err_d;
      end
   end

   assign q         = q_q;
   assign q_rise    = rise_q;
   assign q_fall    = fall_q;
   assign illegal   = ill_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_sr_register_bank.sv
module tb_sr_register_bank;

   logic       clk;
   logic       reset;
   logic       control;
   logic [7:0] s;
   logic [7:0] r;
   logic [1:0] mode;
   logic       clr_err;
   logic [7:0] q;
   logic [7:0] q_rise;
   logic [7:0] q_fall;
   logic [7:0] illegal;
   logic [1:0] err_count;

   sr_register_bank #(
      .CH            (8),
      .CNT_W         (2),
      .RESET_VAL     (8'hA5),
      .FILTER_CYCLES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .control   (control),
      .s         (s),
      .r         (r),
      .mode      (mode),
      .clr_err   (clr_err),
      .q         (q),
      .q_rise    (q_rise),
      .q_fall    (q_fall),
      .illegal   (illegal),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] q;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] ill;
      logic [1:0] err;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Drive one cycle of stimulus and queue the state expected after the next edge
   task automatic step(input string name, input logic rst, input logic ctl,
                       input logic [7:0] sv, input logic [7:0] rv,
                       input logic [1:0] md, input logic clr,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic [7:0] ef, input logic [7:0] ei,
                       input logic [1:0] ee);
      exp_t e;
      @(negedge clk);
      reset   = rst;
      control = ctl;
      s       = sv;
      r       = rv;
      mode    = md;
      clr_err = clr;
      e.name = name; e.q = eq; e.rise = er; e.fall = ef; e.ill = ei; e.err = ee;
      sb.push_back(e);
   endtask

   // Monitor: after every active edge, pop one expectation and compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_total++;
            if ((q === e.q) && (q_rise === e.rise) && (q_fall === e.fall) &&
                (illegal === e.ill) && (err_count === e.err)) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got q=%h rise=%h fall=%h ill=%h err=%0d, want q=%h rise=%h fall=%h ill=%h err=%0d",
                        e.name, q, q_rise, q_fall, illegal, err_count,
                        e.q, e.rise, e.fall, e.ill, e.err);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; control = 1'b0; s = 8'h00; r = 8'h00; mode = 2'b00; clr_err = 1'b0;
      //       name           rst   ctl   s      r      mode   clr   q      rise   fall   ill    err
      step("reset_0",        1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0);
      step("reset_1",        1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0);
`ifdef SR_GLITCH_FILTER_EN
      step("rst_release",    1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_clr_1",        1'b0, 1'b1, 8'h00, 8'hFF, 2'b00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_clr_2",        1'b0, 1'b1, 8'h00, 8'hFF, 2'b00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_clr_3",        1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 2'd0);
      step("f_idle_1",       1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_idle_2",       1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_glitch",       1'b0, 1'b1, 8'h04, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_glitch_1",     1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_glitch_2",     1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_glitch_3",     1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_pulse_1",      1'b0, 1'b1, 8'h04, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_pulse_2",      1'b0, 1'b1, 8'h04, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("f_pulse_3",      1'b0, 1'b1, 8'h04, 8'h00, 2'b00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h00, 2'd0);
      step("f_after",        1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 2'd0);
`else
      step("rst_release",    1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0);
      step("clear_all",      1'b0, 1'b1, 8'h00, 8'hFF, 2'b00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 2'd0);
      step("set_0F",         1'b0, 1'b1, 8'h0F, 8'h00, 2'b00, 1'b0, 8'h0F, 8'h0F, 8'h00, 8'h00, 2'd0);
      step("clr_03",         1'b0, 1'b1, 8'h00, 8'h03, 2'b00, 1'b0, 8'h0C, 8'h00, 8'h03, 8'h00, 2'd0);
      step("gate_hold",      1'b0, 1'b0, 8'hFF, 8'h00, 2'b00, 1'b0, 8'h0C, 8'h00, 8'h00, 8'h00, 2'd0);
      step("gate_open",      1'b0, 1'b1, 8'hFF, 8'h00, 2'b00, 1'b0, 8'hFF, 8'hF3, 8'h00, 8'h00, 2'd0);
      step("clear_all_2",    1'b0, 1'b1, 8'h00, 8'hFF, 2'b00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 2'd0);
      step("gate_strict",    1'b0, 1'b0, 8'h81, 8'h81, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("mode_set",       1'b0, 1'b1, 8'h01, 8'h01, 2'b01, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 2'd0);
      step("mode_reset",     1'b0, 1'b1, 8'h01, 8'h01, 2'b10, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 2'd0);
      step("strict_1",       1'b0, 1'b1, 8'h81, 8'h81, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 2'd1);
      step("strict_2",       1'b0, 1'b1, 8'h81, 8'h81, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 2'd2);
      step("strict_3",       1'b0, 1'b1, 8'h81, 8'h81, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 2'd3);
      step("strict_sat_4",   1'b0, 1'b1, 8'h81, 8'h81, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 2'd3);
      step("strict_sat_5",   1'b0, 1'b1, 8'h81, 8'h81, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h81, 2'd3);
      step("clr_with_ill",   1'b0, 1'b1, 8'h81, 8'h81, 2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h81, 2'd1);
      step("clr_plain",      1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
      step("strict_ch1",     1'b0, 1'b1, 8'h02, 8'h02, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 2'd1);
      step("mode_chg_keep",  1'b0, 1'b1, 8'h02, 8'h02, 2'b01, 1'b0, 8'h02, 8'h02, 8'h00, 8'h02, 2'd1);
      step("toggle_1",       1'b0, 1'b1, 8'h01, 8'h01, 2'b11, 1'b0, 8'h03, 8'h01, 8'h00, 8'h02, 2'd1);
      step("toggle_2",       1'b0, 1'b1, 8'h01, 8'h01, 2'b11, 1'b0, 8'h02, 8'h00, 8'h01, 8'h02, 2'd1);
      step("toggle_3",       1'b0, 1'b1, 8'h01, 8'h01, 2'b11, 1'b0, 8'h03, 8'h01, 8'h00, 8'h02, 2'd1);
      step("toggle_4",       1'b0, 1'b1, 8'h01, 8'h01, 2'b11, 1'b0, 8'h02, 8'h00, 8'h01, 8'h02, 2'd1);
      step("toggle_5",       1'b0, 1'b1, 8'h01, 8'h01, 2'b11, 1'b0, 8'h03, 8'h01, 8'h00, 8'h02, 2'd1);
      step("reset_in_burst", 1'b1, 1'b1, 8'h01, 8'h01, 2'b11, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'd0);
      step("post_reset_clr", 1'b0, 1'b1, 8'h00, 8'hFF, 2'b00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 2'd0);
`endif
      // Give the monitor a bounded window to drain the scoreboard
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sr_register_bank.md
Name: sr_register_bank

Overview:
- Parametrised, clocked successor to the team's level-sensitive SR latch. Provides CH independent SR storage channels behind one shared gate (control).
- Run-time mode selects how s=r=1 is resolved: strict, set-dominant, reset-dominant or toggle.
- Adds per-channel edge pulses, sticky illegal-input flags and a saturating illegal-event counter.
- Sits in the control/status fabric wherever multiple set/clear request lines must be captured synchronously.

Parameters:
- CH, 8, number of SR channels (1..64).
- CNT_W, 8, width of err_count.
- RESET_VAL, {CH{1'b0}}, value loaded into q on reset.
- FILTER_CYCLES, 2, stability window for the optional input filter (1..15); unused when the feature is compiled out.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- control  input  1  gate; 1 = channels may update, 0 = all state holds.
- s  input  CH  per-channel set request.
- r  input  CH  per-channel reset request.
- mode  input  2  s=r=1 resolution: 00 strict, 01 set-dominant, 10 reset-dominant, 11 toggle.
- clr_err  input  1  clears illegal[] and err_count.
- q  output  CH  stored channel values.
- q_rise  output  CH  one-cycle pulse, high in the first cycle q[i] reads 1.
- q_fall  output  CH  one-cycle pulse, high in the first cycle q[i] reads 0.
- illegal  output  CH  sticky flag: channel saw s=r=1 in strict mode.
- err_count  output  CNT_W  saturating count of cycles with any illegal event.

Behaviour:
- All state updates on the rising clk edge only; no latches; all outputs are registered.
- Reset (clk edge with reset=1) has priority over everything:
  - q=RESET_VAL; q_rise=0; q_fall=0; illegal=0; err_count=0.
  - No edge pulses are generated by reset itself.
- control=0: q, illegal and err_count hold; q_rise and q_fall are 0 next cycle; s/r are ignored.
- control=1, per channel i, using the sampled {s[i],r[i]}:
  - 00: hold.
  - 01: q<=0.
  - 10: q<=1.
  - 11, mode 00 (strict): hold; flags an illegal event for channel i.
  - 11, mode 01: q<=1.
  - 11, mode 10: q<=0.
  - 11, mode 11: q<=~q.
- Latency: q reflects s/r sampled at edge N immediately after edge N (1 cycle).
- Edge pulses:
  - q_rise[i] is registered as (q_next[i] & ~q[i]); q_fall[i] as (~q_next[i] & q[i]).
  - Pulses are coincident with the new q value and last exactly one cycle.
  - Toggle mode with s=r=1 held produces alternating rise/fall pulses every cycle.
- illegal[i]:
  - Set on an illegal event.
  - Cleared by clr_err=1. If clr_err and a new illegal event occur in the same cycle, the flag ends at 1.
  - Mode changes do not clear flags.
- err_count:
  - Increments by 1 in each cycle with at least one illegal event, independent of how many channels are illegal.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_err=1 loads 0, or loads 1 if an illegal event occurs in the same cycle.
- mode is sampled every cycle. A mode change takes effect on the same edge it is sampled; no pipeline.
- Reset asserted mid-operation, including during a toggle burst: state is discarded and reset values apply on that edge.

Optional Feature:
- Macro: SR_GLITCH_FILTER_EN.
- Defined:
  - Each channel holds a filtered pair {sf,rf} (reset 00) plus a 4-bit stability counter.
  - The raw {s[i],r[i]} must be unchanged for FILTER_CYCLES consecutive samples before it is copied to {sf,rf}.
  - The counter restarts on any raw change.
  - Counters run regardless of control. Only the commit into q is gated by control.
  - The SR/mode logic uses {sf,rf}. Input-to-q latency becomes FILTER_CYCLES+1 cycles.
  - Pulses shorter than FILTER_CYCLES are fully rejected.
- Undefined: no filter registers; raw s/r feed the logic directly with 1-cycle latency.

Test Plan:
- Reset: hold reset=1 for 2 cycles with RESET_VAL=8'hA5 -> q=8'hA5, q_rise=q_fall=0, illegal=0, err_count=0; no pulses on reset release.
- Basic set/clear: control=1, s=8'h0F, r=0 for 1 cycle, then s=0, r=8'h03 -> q=8'h0F with q_rise=8'h0F, next cycle q=8'h0C with q_fall=8'h03.
- Gate: control=0, s=8'hFF -> q unchanged, q_rise=0; raise control with s still 8'hFF -> q=8'hFF one cycle later.
- Modes, channel 0 with s=r=1:
  - mode 01 -> q[0]=1.
  - mode 10 -> q[0]=0.
  - mode 11 for 4 cycles -> q[0]=1,0,1,0 with alternating rise/fall pulses.
- Strict errors, CNT_W=2:
  - mode 00, s=r=8'h81 for 5 cycles -> q holds, illegal=8'h81, err_count saturates at 3.
  - clr_err concurrent with another illegal cycle -> illegal=8'h81, err_count=1.
- Filter (SR_GLITCH_FILTER_EN, FILTER_CYCLES=2):
  - 1-cycle s[2] pulse -> q[2] unchanged.
  - 3-cycle s[2] pulse -> q[2]=1 exactly 3 cycles after the first high sample.
